// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the RV32 multi-cycle controller.
// Opcode map, FSM states, operand/immediate selects.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    OC_R,
    OC_IALU,
    OC_LOAD,
    OC_STORE,
    OC_BRANCH,
    OC_JAL,
    OC_JALR,
    OC_LUI,
    OC_AUIPC,
    OC_UNKNOWN
  } op_class_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_R      = 7'b0110011;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_TGT   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Operand B is the immediate for everything but reg-reg ops and compares.
  function automatic logic uses_imm(op_class_e c);
    unique case (c)
      OC_IALU, OC_LOAD, OC_STORE,
      OC_JAL, OC_JALR, OC_LUI,
      OC_AUIPC: uses_imm = 1'b1;
      default:  uses_imm = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32_op_classifier.sv
// Combinational opcode classifier: instr[6:0] to op class
// and immediate format for the immediate generator.
module rv32_op_classifier
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_e  op_class,
  output imm_type_e  imm_type
);

  always_comb begin
    op_class = OC_UNKNOWN;
    imm_type = IMM_NONE;
    unique case (opcode)
      OPC_R: begin
        op_class = OC_R;
        imm_type = IMM_NONE;
      end
      OPC_IALU: begin
        op_class = OC_IALU;
        imm_type = IMM_I;
      end
      OPC_LOAD: begin
        op_class = OC_LOAD;
        imm_type = IMM_I;
      end
      OPC_STORE: begin
        op_class = OC_STORE;
        imm_type = IMM_S;
      end
      OPC_BRANCH: begin
        op_class = OC_BRANCH;
        imm_type = IMM_B;
      end
      OPC_JAL: begin
        op_class = OC_JAL;
        imm_type = IMM_J;
      end
      OPC_JALR: begin
        op_class = OC_JALR;
        imm_type = IMM_I;
      end
      OPC_LUI: begin
        op_class = OC_LUI;
        imm_type = IMM_U;
      end
      OPC_AUIPC: begin
        op_class = OC_AUIPC;
        imm_type = IMM_U;
      end
      default: begin
        op_class = OC_UNKNOWN;
        imm_type = IMM_NONE;
      end
    endcase
  end

endmodule

// File: rtl/rv32_mc_ctrl.sv
// Multi-cycle RV32 control FSM: fetch/decode/execute/mem/wb.
// Define CTRL_ILLEGAL_TRAP_EN to trap on unknown opcodes.
module rv32_mc_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             branch_taken,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             alu_src_b,
  output logic [2:0]       imm_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_e           state_q, state_d;
  op_class_e        class_q, class_d;
  imm_type_e        imm_q, imm_d;
  op_class_e        dec_class;
  imm_type_e        dec_imm;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             rd_nz;
  logic             unused_instr;

  assign unused_instr = ^instr[31:12];
  assign rd_nz = |instr[11:7];

  rv32_op_classifier u_cls (
    .opcode   (instr[6:0]),
    .op_class (dec_class),
    .imm_type (dec_imm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      class_q   <= OC_UNKNOWN;
      imm_q     <= IMM_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      imm_q     <= imm_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:
        if (imem_ack) state_d = S_DECODE;
      S_DECODE:
`ifdef CTRL_ILLEGAL_TRAP_EN
        state_d = (dec_class == OC_UNKNOWN)
                ? S_TRAP : S_EXECUTE;
`else
        state_d = S_EXECUTE;
`endif
      S_EXECUTE:
        unique case (class_q)
          OC_LOAD, OC_STORE: state_d = S_MEM;
          OC_BRANCH:         state_d = S_FETCH;
          default:           state_d = S_WB;
        endcase
      S_MEM:
        if (dmem_ack)
          state_d = (class_q == OC_LOAD)
                  ? S_WB : S_FETCH;
      S_WB:   state_d = S_FETCH;
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Class is captured once in DECODE; later outputs never look at instr[6:0].
  assign class_d = (state_q == S_DECODE) ? dec_class : class_q;
  assign imm_d   = (state_q == S_DECODE) ? dec_imm : imm_q;

  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_PLUS4;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    alu_src_b = 1'b0;
    imm_sel   = IMM_NONE;
    if (!rst) begin
      unique case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
        end
        S_EXECUTE: begin
          imm_sel   = imm_q;
          alu_src_b = uses_imm(class_q);
          if (class_q == OC_BRANCH) begin
            pc_we  = 1'b1;
            pc_src = branch_taken ? PC_TGT : PC_PLUS4;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (class_q == OC_STORE);
          pc_we    = dmem_ack && (class_q == OC_STORE);
        end
        S_WB: begin
          reg_we = rd_nz && (class_q != OC_UNKNOWN);
          pc_we  = 1'b1;
          unique case (class_q)
            OC_LOAD: wb_sel = WB_MEM;
            OC_JAL: begin
              wb_sel = WB_PC4;
              pc_src = PC_TGT;
            end
            OC_JALR: begin
              wb_sel = WB_PC4;
              pc_src = PC_JALR;
            end
            default: wb_sel = WB_ALU;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Every retirement coincides with exactly one PC update.
  assign instret_d = instret_q
                   + {{(CNT_W-1){1'b0}}, pc_we};
  assign instret   = instret_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  assign illegal_d = illegal_q
                   | ((state_q == S_DECODE)
                   && (dec_class == OC_UNKNOWN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_rv32_mc_ctrl.sv
// Scoreboard bench for rv32_mc_ctrl: directed instructions,
// expected retire records queued, monitor pops on pc_we.
module tb_rv32_mc_ctrl;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        branch_taken = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic        ir_we, pc_we, reg_we;
  logic [1:0]  pc_src, wb_sel;
  logic        alu_src_b, illegal;
  logic [2:0]  imm_sel;
  logic [31:0] instret;

  always #5 clk = ~clk;

  rv32_mc_ctrl #(.CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .branch_taken (branch_taken),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ack     (dmem_ack),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .alu_src_b    (alu_src_b),
    .imm_sel      (imm_sel),
    .illegal      (illegal),
    .instret      (instret)
  );

  typedef struct {
    logic [31:0] ir;
    logic        tk;
    int          dly;
  } prog_t;

  typedef struct {
    int          lat;
    logic [1:0]  ps;
    logic        rw;
    logic [1:0]  wb;
    int          dr;
    logic        dwe;
    logic        asb;
    logic [2:0]  im;
    logic [31:0] cnt;
  } exp_t;

  prog_t prog_q[$];
  exp_t  exp_q[$];
  prog_t cur;
  exp_t  e;
  int    n_chk = 0;
  int    n_fail = 0;
  int    ddly = 0;
  int    dcnt = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Instruction/data memory and IR model
  always @(posedge clk) begin
    #1;
    if (imem_req && prog_q.size() > 0) begin
      cur = prog_q.pop_front();
      instr = cur.ir;
      branch_taken = cur.tk;
      ddly = cur.dly;
      imem_ack = 1'b1;
    end else begin
      imem_ack = 1'b0;
    end
    if (dmem_req) begin
      dmem_ack = (dcnt == ddly);
      dcnt = dmem_ack ? 0 : dcnt + 1;
    end else begin
      dmem_ack = 1'b0;
      dcnt = 0;
    end
  end

  // Monitor
  int          rel = 0;
  int          dcyc = 0;
  bit          active = 0;
  bit          pend = 0;
  logic [31:0] pend_cnt;
  logic        dwe_s, asb_s;
  logic [2:0]  imm_s;

  always @(negedge clk) begin
    if (rst) begin
      active = 0;
      pend = 0;
    end else begin
      if (pend) begin
        chk("instret", instret, pend_cnt);
        pend = 0;
      end
      if (ir_we) begin
        chk("ir_we_on_ack", {31'b0, imem_req & imem_ack}, 1);
        active = 1;
        rel = 1;
        dcyc = 0;
        dwe_s = 0;
        asb_s = 0;
        imm_s = 0;
      end else if (active) begin
        rel++;
      end
      if (active && rel == 3) begin
        asb_s = alu_src_b;
        imm_s = imm_sel;
      end
      if (dmem_req) begin
        dcyc++;
        dwe_s |= dmem_we;
      end
      if (reg_we)
        chk("reg_we_with_pc_we", {31'b0, pc_we}, 1);
      if (pc_we) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL retire: unexpected pc_we, instret=%0d",
                   instret);
        end else begin
          e = exp_q.pop_front();
          chk("latency", rel, e.lat);
          chk("pc_src", {30'b0, pc_src}, {30'b0, e.ps});
          chk("reg_we", {31'b0, reg_we}, {31'b0, e.rw});
          chk("wb_sel", {30'b0, wb_sel}, {30'b0, e.wb});
          chk("dmem_req_cycles", dcyc, e.dr);
          chk("dmem_we", {31'b0, dwe_s}, {31'b0, e.dwe});
          chk("alu_src_b", {31'b0, asb_s}, {31'b0, e.asb});
          chk("imm_sel", {29'b0, imm_s}, {29'b0, e.im});
          pend = 1;
          pend_cnt = e.cnt;
        end
        active = 0;
      end
    end
  end

  task automatic issue(logic [31:0] ir, logic tk, int dly,
                       int lat, logic [1:0] ps, logic rw,
                       logic [1:0] wb, int dr, logic dwe,
                       logic asb, imm_type_e im,
                       logic [31:0] cnt);
    exp_t  x;
    prog_t p;
    x.lat = lat; x.ps = ps; x.rw = rw; x.wb = wb;
    x.dr = dr; x.dwe = dwe; x.asb = asb;
    x.im = im; x.cnt = cnt;
    p.ir = ir; p.tk = tk; p.dly = dly;
    exp_q.push_back(x);
    prog_q.push_back(p);
  endtask

  task automatic drain(int maxc);
    int c = 0;
    while ((exp_q.size() != 0 || pend) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() != 0 || pend) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d records left after %0d cycles",
               exp_q.size(), maxc);
      exp_q.delete();
      prog_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    prog_q.delete();
    exp_q.delete();
    #1;
    chk("rst_imem_req", {31'b0, imem_req}, 0);
    chk("rst_dmem_req", {31'b0, dmem_req}, 0);
    chk("rst_instret", instret, 0);
    chk("rst_illegal", {31'b0, illegal}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_imem_req", {31'b0, imem_req}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    #1;
    chk("init_imem_req", {31'b0, imem_req}, 0);
    chk("init_ir_we", {31'b0, ir_we}, 0);
    chk("init_instret", instret, 0);
    chk("init_illegal", {31'b0, illegal}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("first_imem_req", {31'b0, imem_req}, 1);

    // ir, tk, dly, lat, pc_src, reg_we, wb, dreq, dwe, asb, imm, instret
    issue(32'h00500093, 0, 0, 4, PC_PLUS4, 1, WB_ALU, 0, 0, 1, IMM_I, 1);
    issue(32'h0000A103, 0, 3, 8, PC_PLUS4, 1, WB_MEM, 4, 0, 1, IMM_I, 2);
    issue(32'h00000463, 1, 0, 3, PC_TGT,   0, WB_ALU, 0, 0, 0, IMM_B, 3);
    issue(32'h00000463, 0, 0, 3, PC_PLUS4, 0, WB_ALU, 0, 0, 0, IMM_B, 4);
    issue(32'h00102023, 0, 0, 4, PC_PLUS4, 0, WB_ALU, 1, 1, 1, IMM_S, 5);
    issue(32'h00208033, 0, 0, 4, PC_PLUS4, 0, WB_ALU, 0, 0, 0, IMM_NONE, 6);
    issue(32'h010000EF, 0, 0, 4, PC_TGT,   1, WB_PC4, 0, 0, 1, IMM_J, 7);
    issue(32'h00008067, 0, 0, 4, PC_JALR,  0, WB_PC4, 0, 0, 1, IMM_I, 8);
    issue(32'h000122B7, 0, 0, 4, PC_PLUS4, 1, WB_ALU, 0, 0, 1, IMM_U, 9);
    issue(32'h00001197, 0, 0, 4, PC_PLUS4, 1, WB_ALU, 0, 0, 1, IMM_U, 10);
    issue(32'h0000A103, 0, 0, 5, PC_PLUS4, 1, WB_MEM, 1, 0, 1, IMM_I, 11);
    drain(200);

    // Reset while a load is waiting in MEM
    do_reset();
    begin
      prog_t p;
      int c;
      p.ir = 32'h0000A103; p.tk = 0; p.dly = 20;
      prog_q.push_back(p);
      c = 0;
      while (!dmem_req && c < 20) begin
        @(negedge clk);
        c++;
      end
      chk("mem_reached", {31'b0, dmem_req}, 1);
      @(negedge clk);
      chk("mem_still_waiting", {31'b0, dmem_req}, 1);
      rst = 1'b1;
      prog_q.delete();
      #1;
      chk("midrst_dmem_req", {31'b0, dmem_req}, 0);
      chk("midrst_imem_req", {31'b0, imem_req}, 0);
      chk("midrst_instret", instret, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_fetch", {31'b0, imem_req}, 1);
      chk("midrst_dmem_off", {31'b0, dmem_req}, 0);
      chk("midrst_instret_after", instret, 0);
    end

    // Unknown opcode 0x7F
    do_reset();
`ifdef CTRL_ILLEGAL_TRAP_EN
    begin
      prog_t p;
      p.ir = 32'h0000007F; p.tk = 0; p.dly = 0;
      prog_q.push_back(p);
      repeat (6) @(negedge clk);
      chk("trap_illegal", {31'b0, illegal}, 1);
      chk("trap_imem_req", {31'b0, imem_req}, 0);
      p.ir = 32'h00500093;
      prog_q.push_back(p);
      repeat (6) @(negedge clk);
      chk("trap_held", {31'b0, illegal}, 1);
      chk("trap_instret", instret, 0);
      chk("trap_ir_we", {31'b0, ir_we}, 0);
    end
    do_reset();
    chk("trap_cleared", {31'b0, illegal}, 0);
`else
    issue(32'h0000007F, 0, 0, 4, PC_PLUS4, 0, WB_ALU, 0, 0, 0, IMM_NONE, 1);
    drain(50);
    chk("nop_illegal", {31'b0, illegal}, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
